screen_fetcher: RTL

- Display-side reader of video RAM: generates the screen_fetch/screen_addr (and ULAplus screen_fetch_up/screen_up_addr) requests that the memory controller serves ahead of CPU traffic.
- Captures bitmap/attribute bytes from vd, double-buffers them, serialises pixels at 7 MHz.
- Sits between video timing (hc/vc/ck7) and the palette/DAC logic.

---
 rtl/screen_fetcher_pkg.sv | 23 ++
 rtl/screen_fetcher_shift_reg.sv | 31 +++
 rtl/screen_fetcher.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/screen_fetcher_pkg.sv
// Shared constants and address helpers for the display fetch path.
package screen_fetcher_pkg;

    localparam logic [4:0]  SLOT_BITMAP   = 5'd16;
    localparam logic [4:0]  SLOT_ATTR     = 5'd20;
    localparam logic [4:0]  SLOT_UP_INK   = 5'd24;
    localparam logic [4:0]  SLOT_UP_PAPER = 5'd28;

    localparam logic [8:0]  PAPER_W = 9'd256;
    localparam logic [8:0]  PAPER_H = 9'd192;

    localparam logic [12:0] ATTR_BASE = 13'h1800;

    // Bitmap rows are interleaved: third, pixel row, character row, column.
    function automatic logic [14:0] bitmap_addr(input logic [7:0] y, input logic [4:0] col);
        return {2'b10, y[7:6], y[2:0], y[5:3], col};
    endfunction

    function automatic logic [14:0] attr_addr(input logic [7:0] y, input logic [4:0] col);
        return {2'b10, ATTR_BASE | {3'b000, y[7:3], col}};
    endfunction

endpackage

// File: rtl/screen_fetcher_shift_reg.sv
// Bitmap byte buffer plus MSB-first pixel shifter advanced on ck7.
module screen_shift_reg
    import screen_fetcher_pkg::*;
(
    input  logic       clk28,
    input  logic       rst,
    input  logic       ck7,
    input  logic       cap,
    input  logic       load,
    input  logic [7:0] vd,
    output logic       msb
);

    logic [7:0] bmp_q;
    logic [7:0] shift_q;

    always_ff @(posedge clk28) begin
        if (rst) begin
            bmp_q   <= 8'h00;
            shift_q <= 8'h00;
        end else begin
            if (cap)
                bmp_q <= vd;
            if (ck7)
                shift_q <= load ? bmp_q : {shift_q[6:0], 1'b0};
        end
    end

    assign msb = shift_q[7];

endmodule

// File: rtl/screen_fetcher.sv
// Display-side VRAM fetch scheduler, attribute/pixel pipeline and flash timer.
// Optional ULAplus palette fetches are built when ULAPLUS_EN is defined.
module screen_fetcher
    import screen_fetcher_pkg::*;
#(
    parameter int FLASH_DIV = 16
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        ck7,
    input  logic [8:0]  hc,
    input  logic [8:0]  vc,
    input  logic [7:0]  vd,
    input  logic        up_en,
    output logic        screen_fetch,
    output logic        screen_fetch_up,
    output logic [14:0] screen_addr,
    output logic [5:0]  screen_up_addr,
    output logic        pixel,
    output logic [7:0]  attr,
    output logic [7:0]  up_ink,
    output logic [7:0]  up_paper,
    output logic        paper,
    output logic        flash_phase
);

    localparam int FW = $clog2(FLASH_DIV);

    logic [1:0]    ph_q;
    logic [1:0]    p;
    logic [4:0]    sub;
    logic          fetch_line, cap_cyc, load_pt;
    logic          in_bmp, in_attr, in_ink, in_pap;
    logic [14:0]   addr_q;
    logic [7:0]    attr_buf, attr_q;
    logic          col_q, loaded_q;
    logic [FW-1:0] frame_q;
    logic          flash_q;
    logic          flash_mask;
    logic          shift_msb;

    // Sub-pixel phase restarts on every ck7 and parks at 3.
    always_ff @(posedge clk28) begin
        if (rst)
            ph_q <= 2'd3;
        else if (ck7)
            ph_q <= 2'd1;
        else if (ph_q != 2'd3)
            ph_q <= ph_q + 2'd1;
    end

    assign p          = ck7 ? 2'd0 : ph_q;
    assign sub        = {hc[2:0], p};
    assign fetch_line = (vc < PAPER_H) && (hc < PAPER_W);
    assign cap_cyc    = (p == 2'd1);
    assign load_pt    = ck7 && (hc[2:0] == 3'd0);
    assign in_bmp     = fetch_line && (sub[4:1] == SLOT_BITMAP[4:1]);
    assign in_attr    = fetch_line && (sub[4:1] == SLOT_ATTR[4:1]);

    assign screen_fetch = !rst && (in_bmp || in_attr || in_ink || in_pap);

    always_comb begin
        screen_addr = addr_q;
        if (rst)
            screen_addr = 15'h0000;
        else if (in_bmp)
            screen_addr = bitmap_addr(vc[7:0], hc[7:3]);
        else if (in_attr)
            screen_addr = attr_addr(vc[7:0], hc[7:3]);
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            addr_q   <= 15'h0000;
            attr_buf <= 8'h00;
            attr_q   <= 8'h00;
            col_q    <= 1'b0;
            loaded_q <= 1'b0;
            frame_q  <= '0;
            flash_q  <= 1'b0;
        end else begin
            addr_q <= screen_addr;
            if (load_pt) begin
                loaded_q <= col_q;
                attr_q   <= col_q ? attr_buf : 8'h00;
                col_q    <= 1'b0;
            end
            if (in_bmp && cap_cyc)
                col_q <= 1'b1;
            if (in_attr && cap_cyc)
                attr_buf <= vd;
            if (ck7 && hc == 9'd0 && vc == 9'd0) begin
                frame_q <= frame_q + 1'b1;
                if (frame_q == FW'(FLASH_DIV - 1))
                    flash_q <= ~flash_q;
            end
        end
    end

    screen_shift_reg u_shift (
        .clk28 (clk28),
        .rst   (rst),
        .ck7   (ck7),
        .cap   (in_bmp && cap_cyc),
        .load  (load_pt && col_q),
        .vd    (vd),
        .msb   (shift_msb)
    );

`ifdef ULAPLUS_EN
    logic       up_act_q;
    logic [5:0] up_addr_q;
    logic [7:0] ink_buf, pap_buf, ink_q, pap_q;

    // Palette mode is latched per character so a mid-line toggle never splits a column.
    assign in_ink     = fetch_line && up_act_q && (sub[4:1] == SLOT_UP_INK[4:1]);
    assign in_pap     = fetch_line && up_act_q && (sub[4:1] == SLOT_UP_PAPER[4:1]);
    assign flash_mask = ~up_en;
    assign screen_fetch_up = !rst && (in_ink || in_pap);
    assign up_ink     = ink_q;
    assign up_paper   = pap_q;

    always_comb begin
        screen_up_addr = up_addr_q;
        if (rst)
            screen_up_addr = 6'h00;
        else if (in_ink)
            screen_up_addr = {attr_buf[7:6], 1'b0, attr_buf[2:0]};
        else if (in_pap)
            screen_up_addr = {attr_buf[7:6], 1'b1, attr_buf[5:3]};
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            up_act_q  <= 1'b0;
            up_addr_q <= 6'h00;
            ink_buf   <= 8'h00;
            pap_buf   <= 8'h00;
            ink_q     <= 8'h00;
            pap_q     <= 8'h00;
        end else begin
            up_addr_q <= screen_up_addr;
            if (load_pt) begin
                up_act_q <= up_en;
                ink_q    <= col_q ? ink_buf : 8'h00;
                pap_q    <= col_q ? pap_buf : 8'h00;
            end
            if (in_ink && cap_cyc)
                ink_buf <= vd;
            if (in_pap && cap_cyc)
                pap_buf <= vd;
        end
    end
`else
    logic unused_up_en;

    assign unused_up_en    = up_en;
    assign in_ink          = 1'b0;
    assign in_pap          = 1'b0;
    assign flash_mask      = 1'b1;
    assign screen_fetch_up = 1'b0;
    assign screen_up_addr  = 6'h00;
    assign up_ink          = 8'h00;
    assign up_paper        = 8'h00;
`endif

    assign paper       = loaded_q;
    assign attr        = attr_q;
    assign flash_phase = flash_q;
    assign pixel       = loaded_q && (shift_msb ^ (attr_q[7] & flash_q & flash_mask));

endmodule
